// File: rtl/manual_drive_pkg.sv
// Shared encodings for the manual-transmission driving controller:
// one-hot drive states and lamp bit positions within the answer bus.
package manual_drive_pkg;

  localparam logic [3:0] ST_POWER_OFF    = 4'b0001;
  localparam logic [3:0] ST_NOT_STARTING = 4'b0010;
  localparam logic [3:0] ST_STARTING     = 4'b0100;
  localparam logic [3:0] ST_MOVING       = 4'b1000;

  localparam int ANS_LEFT    = 3;
  localparam int ANS_RIGHT   = 2;
  localparam int ANS_REVERSE = 1;
  localparam int ANS_MOVING  = 0;

endpackage

// File: rtl/manual_drive_ctrl_blinker.sv
// Turn/hazard lamp blinker: both lamps share one phase counter so that
// hazard mode blinks in phase; the phase restarts after an idle cycle.
module turn_lamp_blinker #(
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic left,
  input  logic right,
  output logic left_lamp,
  output logic right_lamp
);

  localparam int PW = $clog2(2 * BLINK_HALF);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * BLINK_HALF - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(BLINK_HALF);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_use;
  logic          any_now;
  logic          any_prev;
  logic          lamp_on;

  assign any_now   = enable & (left | right);
  // a fresh activation always starts on the ON half
  assign phase_use = any_prev ? phase : '0;
  assign lamp_on   = (phase_use < PHASE_HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      any_prev   <= 1'b0;
      left_lamp  <= 1'b0;
      right_lamp <= 1'b0;
    end else begin
      any_prev   <= any_now;
      left_lamp  <= any_now & left & lamp_on;
      right_lamp <= any_now & right & lamp_on;
      if (!any_now)
        phase <= '0;
      else if (phase_use == PHASE_LAST)
        phase <= '0;
      else
        phase <= phase_use + 1'b1;
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive controller: hold-to-toggle power switch,
// four-state drive FSM, lamp outputs and a wrapping mileage counter.
//
// state           | meaning
// ST_POWER_OFF    | car off, all lamps dark
// ST_NOT_STARTING | powered, engine not engaged
// ST_STARTING     | clutch engaged, ready to pull away
// ST_MOVING       | driving, mileage accumulates
module manual_drive_ctrl
  import manual_drive_pkg::*;
#(
  parameter int POWER_HOLD = 100_000_000,
  parameter int BLINK_HALF = 50_000_000,
  parameter int MILE_TICK  = 100_000_000,
  parameter int MILE_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_input,
  input  logic              throttle,
  input  logic              clutch,
  input  logic              brake,
  input  logic              reverse,
  input  logic              turn_left_signal,
  input  logic              turn_right_signal,
  output logic [3:0]        state,
  output logic [3:0]        answer,
  output logic              power_now,
  output logic [MILE_W-1:0] mileage
);

  localparam int HW = $clog2(POWER_HOLD + 1);
  localparam int TW = $clog2(MILE_TICK + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(POWER_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(POWER_HOLD);
  localparam logic [TW-1:0] TICK_LAST = TW'(MILE_TICK - 1);

  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tick_cnt;
  logic          toggle;
  logic          rev_prev;
  logic [3:0]    state_nxt;
  logic          powered_nxt;
  logic          left_lamp;
  logic          right_lamp;
  logic          rev_lamp_q;
  logic          mov_lamp_q;

  // saturating at POWER_HOLD makes a long press yield exactly one toggle
  assign toggle = power_input && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= '0;
    else if (!power_input)
      hold_cnt <= '0;
    else if (hold_cnt != HOLD_SAT)
      hold_cnt <= hold_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_POWER_OFF: begin
        if (toggle) state_nxt = ST_NOT_STARTING;
      end
      ST_NOT_STARTING: begin
        if (toggle)                    state_nxt = ST_POWER_OFF;
        else if (throttle && !clutch)  state_nxt = ST_POWER_OFF;
        else if (throttle && clutch)   state_nxt = ST_STARTING;
      end
      ST_STARTING: begin
        if (toggle)                    state_nxt = ST_POWER_OFF;
        else if (brake)                state_nxt = ST_NOT_STARTING;
        else if (throttle && !clutch)  state_nxt = ST_MOVING;
      end
      ST_MOVING: begin
        if (toggle)                                 state_nxt = ST_POWER_OFF;
        else if ((reverse != rev_prev) && !clutch)  state_nxt = ST_POWER_OFF;
        else if (brake)                             state_nxt = ST_NOT_STARTING;
        else if (clutch || !throttle)               state_nxt = ST_STARTING;
      end
      default: state_nxt = ST_POWER_OFF;
    endcase
  end

  assign powered_nxt = (state_nxt != ST_POWER_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_POWER_OFF;
      power_now  <= 1'b0;
      rev_prev   <= 1'b0;
      rev_lamp_q <= 1'b0;
      mov_lamp_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      power_now  <= powered_nxt;
      rev_prev   <= reverse;
      rev_lamp_q <= powered_nxt & reverse;
      mov_lamp_q <= (state_nxt == ST_MOVING);
    end
  end

  // partial tick is frozen outside MOVING and resumes on return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      mileage  <= '0;
    end else if (state == ST_MOVING) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        mileage  <= mileage + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  turn_lamp_blinker #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blinker (
    .clk        (clk),
    .rst        (rst),
    .enable     (powered_nxt),
    .left       (turn_left_signal),
    .right      (turn_right_signal),
    .left_lamp  (left_lamp),
    .right_lamp (right_lamp)
  );

  always_comb begin
    answer              = '0;
    answer[ANS_LEFT]    = left_lamp;
    answer[ANS_RIGHT]   = right_lamp;
    answer[ANS_REVERSE] = rev_lamp_q;
    answer[ANS_MOVING]  = mov_lamp_q;
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Self-checking bench for manual_drive_ctrl: a behavioural model pushes the
// expected outputs for every cycle into a queue, popped after each edge.
module tb_manual_drive_ctrl;

  localparam int PH = 4;
  localparam int BH = 3;
  localparam int MT = 5;
  localparam int MW = 4;

  localparam logic [3:0] S_OFF = 4'b0001;
  localparam logic [3:0] S_NS  = 4'b0010;
  localparam logic [3:0] S_ST  = 4'b0100;
  localparam logic [3:0] S_MV  = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  logic power_input, throttle, clutch, brake, reverse;
  logic turn_left_signal, turn_right_signal;
  logic [3:0]    state;
  logic [3:0]    answer;
  logic          power_now;
  logic [MW-1:0] mileage;

  manual_drive_ctrl #(
    .POWER_HOLD (PH),
    .BLINK_HALF (BH),
    .MILE_TICK  (MT),
    .MILE_W     (MW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .power_input       (power_input),
    .throttle          (throttle),
    .clutch            (clutch),
    .brake             (brake),
    .reverse           (reverse),
    .turn_left_signal  (turn_left_signal),
    .turn_right_signal (turn_right_signal),
    .state             (state),
    .answer            (answer),
    .power_now         (power_now),
    .mileage           (mileage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [3:0]    ans;
    logic          pw;
    logic [MW-1:0] mi;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_bad   = 0;

  int         m_hold, m_phase, m_tick, m_mile;
  logic [3:0] m_state;
  logic       m_rev_prev, m_any_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_phase = 0; m_tick = 0; m_mile = 0;
    m_state = S_OFF; m_rev_prev = 1'b0; m_any_prev = 1'b0;
  endtask

  task automatic model_step();
    exp_t e;
    logic toggle, any, lamp_on, pw;
    logic [3:0] ns;
    m_hold = power_input ? m_hold + 1 : 0;
    toggle = (m_hold == PH);
    ns = m_state;
    if (toggle)
      ns = (m_state == S_OFF) ? S_NS : S_OFF;
    else begin
      case (m_state)
        S_NS: if (throttle) ns = clutch ? S_ST : S_OFF;
        S_ST: begin
          if (brake) ns = S_NS;
          else if (throttle && !clutch) ns = S_MV;
        end
        S_MV: begin
          if ((reverse !== m_rev_prev) && !clutch) ns = S_OFF;
          else if (brake) ns = S_NS;
          else if (clutch || !throttle) ns = S_ST;
        end
        default: ;
      endcase
    end
    if (m_state == S_MV) begin
      m_tick++;
      if (m_tick == MT) begin
        m_tick = 0;
        m_mile = (m_mile + 1) % (1 << MW);
      end
    end
    m_rev_prev = reverse;
    pw  = (ns != S_OFF);
    any = pw && (turn_left_signal || turn_right_signal);
    if (any) m_phase = m_any_prev ? m_phase + 1 : 0;
    lamp_on = ((m_phase / BH) % 2) == 0;
    m_any_prev = any;
    e.st  = ns;
    e.ans = {any && turn_left_signal && lamp_on, any && turn_right_signal && lamp_on,
             pw && reverse, ns == S_MV};
    e.pw  = pw;
    e.mi  = MW'(m_mile);
    m_state = ns;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("state",     32'(state),     32'(e.st));
      check_val("answer",    32'(answer),    32'(e.ans));
      check_val("power_now", 32'(power_now), 32'(e.pw));
      check_val("mileage",   32'(mileage),   32'(e.mi));
    end
  endtask

  initial begin
    logic [5:0] pat;
    int mb;
    int guard;
    pat = 6'b111000;
    rst = 1'b1;
    power_input = 0; throttle = 0; clutch = 0; brake = 0; reverse = 0;
    turn_left_signal = 0; turn_right_signal = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state",   32'(state),     32'(S_OFF));
    check_val("rst_answer",  32'(answer),    32'd0);
    check_val("rst_power",   32'(power_now), 32'd0);
    check_val("rst_mileage", 32'(mileage),   32'd0);
    #4 rst = 1'b0;

    // short press does nothing, full press powers on once
    power_input = 1; cyc(3);
    power_input = 0; cyc(1);
    check_val("short_press", 32'(state), 32'(S_OFF));
    power_input = 1; cyc(4);
    check_val("press_on", 32'(state), 32'(S_NS));
    check_val("press_pw", 32'(power_now), 32'd1);
    cyc(10);
    check_val("held_once", 32'(state), 32'(S_NS));
    power_input = 0; cyc(1);

    // stall, then normal start sequence
    throttle = 1; cyc(1);
    check_val("stall", 32'(state), 32'(S_OFF));
    throttle = 0;
    power_input = 1; cyc(4);
    power_input = 0;
    check_val("repower", 32'(state), 32'(S_NS));
    clutch = 1; throttle = 1; cyc(1);
    check_val("starting", 32'(state), 32'(S_ST));
    clutch = 0; cyc(1);
    check_val("moving", 32'(state), 32'(S_MV));
    brake = 1; cyc(1);
    check_val("brake", 32'(state), 32'(S_NS));
    brake = 0; throttle = 0;

    // reverse change without clutch stalls
    clutch = 1; throttle = 1; cyc(1);
    clutch = 0; cyc(1);
    reverse = 1; cyc(1);
    check_val("rev_stall", 32'(state), 32'(S_OFF));
    throttle = 0; reverse = 0; cyc(1);
    power_input = 1; cyc(4);
    power_input = 0;
    clutch = 1; throttle = 1; cyc(1);
    clutch = 0; cyc(1);
    // reverse change with clutch held: clutch drops back to STARTING, no stall
    clutch = 1; reverse = 1; cyc(1);
    check_val("rev_clutch", 32'(state), 32'(S_ST));
    check_val("rev_lamp", 32'(answer[1]), 32'd1);
    clutch = 0; cyc(1);
    check_val("rev_moving", 32'(state), 32'(S_MV));

    // 80 moving cycles = 16 increments, wraps back to the same value
    mb = m_mile;
    cyc(80);
    check_val("mile_wrap", 32'(mileage), 32'(mb));

    // partial tick frozen while away from MOVING
    cyc(2);
    brake = 1; cyc(1);
    brake = 0; throttle = 0; cyc(2);
    clutch = 1; throttle = 1; cyc(1);
    clutch = 0; cyc(7);

    // turn lamp and hazard blink patterns
    brake = 1; cyc(1);
    brake = 0; throttle = 0;
    turn_left_signal = 1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check_val("left_blink", 32'(answer[3]), 32'(pat[5 - (i % 6)]));
    end
    turn_left_signal = 0; cyc(1);
    turn_left_signal = 1; turn_right_signal = 1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check_val("hazard", 32'(answer[3:2]), pat[5 - (i % 6)] ? 32'd3 : 32'd0);
    end
    power_input = 1; cyc(4);
    check_val("off_lamps", 32'(answer), 32'd0);
    check_val("off_state", 32'(state), 32'(S_OFF));
    power_input = 0; turn_left_signal = 0; turn_right_signal = 0; cyc(1);

    // async reset in the middle of MOVING
    power_input = 1; cyc(4);
    power_input = 0;
    clutch = 1; throttle = 1; cyc(1);
    clutch = 0; cyc(1);
    guard = 0;
    while (m_mile != 7 && guard < 200) begin
      cyc(1);
      guard++;
    end
    check_val("pre_rst_mile",  32'(mileage), 32'd7);
    check_val("pre_rst_state", 32'(state),   32'(S_MV));
    #2 rst = 1'b1;
    #1;
    check_val("arst_state",   32'(state),     32'(S_OFF));
    check_val("arst_answer",  32'(answer),    32'd0);
    check_val("arst_mileage", 32'(mileage),   32'd0);
    check_val("arst_power",   32'(power_now), 32'd0);
    model_reset();
    sb_q.delete();
    throttle = 0; clutch = 0; brake = 0; reverse = 0;
    #3 rst = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
